// File: rtl/unpad_pkg.sv
// Shared types and field positions for the padded-block unpacker.
// Block layout: [255:248] length in bits, [247:0] message plus zero padding.
package unpad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_t;

  localparam int BLOCK_W = 256;
  localparam int LEN_MSB = 255;
  localparam int LEN_LSB = 248;
  localparam int BYTE_W  = 8;
  localparam int MSG_W   = LEN_LSB;
  localparam int CNT_W   = 6;

  // Ones on message bit positions below leff, zeros on the padding.
  function automatic logic [MSG_W-1:0] keep_mask(input logic [7:0] leff);
    return ~({MSG_W{1'b1}} << leff);
  endfunction

endpackage

// File: rtl/unpad_stream_pad_check.sv
// Combinational padding check: flags any set bit at or above the effective length.
// Zero latency, no handshake.
module pad_check
  import unpad_pkg::*;
(
  input  logic [MSG_W-1:0] block,
  input  logic [7:0]       Leff,
  output logic             nonzero_pad
);

  assign nonzero_pad = |(block & ~keep_mask(Leff));

endmodule

// File: rtl/unpad_stream.sv
// Strips padding from a 256-bit block and streams the message LSB byte first; the
// padding check is built only with UNPAD_CHECK_EN, otherwise pad_err reports length overflow alone.
module unpad_stream
  import unpad_pkg::*;
#(
  parameter int MAX_LEN = 248
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] paddedText,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         done,
  output logic         pad_err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t           r_state;
  state_t           w_next;
  logic [MSG_W-1:0] r_msg;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nbytes;
  logic             r_err;

  logic [7:0]       w_len;
  logic [7:0]       w_leff;
  logic             w_len_err;
  logic             w_err;
  logic             w_capture;
  logic             w_byte_hs;
  logic             w_last;
  logic [CNT_W-1:0] w_nbytes;
  logic [7:0]       w_byte;

  assign w_len     = paddedText[LEN_MSB:LEN_LSB];
  assign w_len_err = (w_len > MAX_LEN_B);
  assign w_leff    = w_len_err ? MAX_LEN_B : w_len;
  assign w_nbytes  = CNT_W'(({1'b0, w_leff} + 9'd7) >> 3);

`ifdef UNPAD_CHECK_EN
  logic w_nonzero_pad;

  pad_check u_pad_check (
    .block       (paddedText[MSG_W-1:0]),
    .Leff        (w_leff),
    .nonzero_pad (w_nonzero_pad)
  );

  assign w_err = w_len_err | w_nonzero_pad;
`else
  assign w_err = w_len_err;
`endif

  assign w_capture = (r_state == IDLE) && in_valid;
  assign w_byte_hs = (r_state == STREAM) && out_ready;
  assign w_last    = (r_cnt == r_nbytes - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = (w_leff == 8'd0) ? FIN : STREAM;
      STREAM:  if (out_ready && w_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Padding is cleared at capture so the last byte comes out already masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg    <= '0;
      r_cnt    <= '0;
      r_nbytes <= '0;
      r_err    <= 1'b0;
    end else if (w_capture) begin
      r_msg    <= paddedText[MSG_W-1:0] & keep_mask(w_leff);
      r_cnt    <= '0;
      r_nbytes <= w_nbytes;
      r_err    <= w_err;
    end else if (w_byte_hs) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < MSG_W / BYTE_W; k++) begin
      if (r_cnt == CNT_W'(k)) w_byte = r_msg[k*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    pad_err   = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      STREAM: begin
        out_valid = 1'b1;
        out_last  = w_last;
        out_data  = w_byte;
      end
      FIN: begin
        done    = 1'b1;
        pad_err = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unpad_stream.sv
// Directed and random blocks checked against a bit-level reference of the unpadding rules.
module tb_unpad_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] paddedText;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         done;
  logic         pad_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_b [32];
  int         exp_n;
  logic       exp_err;

  unpad_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .paddedText (paddedText),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .done       (done),
    .pad_err    (pad_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: expected byte list and error flag straight from the block layout rules.
  task automatic model(input logic [255:0] blk);
    int len;
    int leff;
    len     = int'(blk[255:248]);
    leff    = (len > 248) ? 248 : len;
    exp_n   = (leff + 7) / 8;
    exp_err = (len > 248);
    for (int k = 0; k < 32; k++) exp_b[k] = 8'h00;
    for (int k = 0; k < exp_n; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (8*k + j < leff) exp_b[k][j] = blk[8*k + j];
      end
    end
`ifdef UNPAD_CHECK_EN
    for (int p = leff; p < 248; p++) if (blk[p]) exp_err = 1'b1;
`endif
  endtask

  function automatic logic [255:0] rand_blk(input int len, input bit clean_pad);
    logic [255:0] b;
    int lim;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    b[255:248] = 8'(len);
    lim = (len > 248) ? 248 : len;
    if (clean_pad) for (int p = lim; p < 248; p++) b[p] = 1'b0;
    return b;
  endfunction

  task automatic run_block(input string tag, input logic [255:0] blk, input int rdy_pct,
                           input int stall_at);
    int   k;
    int   cyc;
    int   hold;
    logic rdy;
    model(blk);
    chk({tag, "/in_ready_idle"}, in_ready, 1);
    paddedText = blk;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_n == 0) chk({tag, "/done_after_capture"}, done, 1);
    else            chk({tag, "/first_valid"}, out_valid, 1);
    k    = 0;
    cyc  = 0;
    hold = 0;
    while (done !== 1'b1 && cyc < 400) begin
      chk({tag, "/in_ready_busy"}, in_ready, 0);
      in_valid   = 1'($urandom_range(0, 1));
      paddedText = rand_blk($urandom_range(0, 255), 1'b0);
      if (out_valid === 1'b1) begin
        if (k >= exp_n) begin
          chk({tag, "/extra_byte"}, out_valid, 0);
        end else begin
          chk({tag, "/data"}, out_data, exp_b[k]);
          chk({tag, "/last"}, out_last, (k == exp_n - 1));
        end
        if (k == stall_at && hold < 3) begin
          rdy = 1'b0;
          hold++;
        end else begin
          rdy = ($urandom_range(1, 100) <= rdy_pct);
        end
        out_ready = rdy;
        if (rdy) k++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "/done"}, done, 1);
    chk({tag, "/byte_count"}, k, exp_n);
    chk({tag, "/pad_err"}, pad_err, exp_err);
    chk({tag, "/valid_at_done"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "/done_one_cycle"}, done, 0);
    chk({tag, "/in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [255:0] b;
    rst_n      = 1'b0;
    paddedText = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/out_valid", out_valid, 0);
    chk("rst/out_last", out_last, 0);
    chk("rst/out_data", out_data, 0);
    chk("rst/done", done, 0);
    chk("rst/pad_err", pad_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst/in_ready", in_ready, 1);

    b = '0; b[255:248] = 8'd16; b[15:0] = 16'hBEEF;
    run_block("beef", b, 100, -1);

    b = '0; b[255:248] = 8'd12; b[15:0] = 16'hFABC;
    run_block("mask12", b, 100, -1);

    b = rand_blk(0, 1'b1);
    run_block("len0", b, 100, -1);

    b = rand_blk(250, 1'b0);
    run_block("len250", b, 100, -1);

    b = '0; b[255:248] = 8'd8; b[7:0] = 8'h5A; b[100] = 1'b1;
    run_block("pad_bit100", b, 100, -1);

    b = rand_blk(248, 1'b1);
    run_block("len248", b, 70, -1);

    b = rand_blk(249, 1'b1);
    run_block("len249", b, 70, -1);

    b = rand_blk(64, 1'b1);
    run_block("stall3", b, 100, 2);

    for (int i = 0; i < 40; i++) begin
      b = rand_blk($urandom_range(0, 255), 1'($urandom_range(0, 1)));
      run_block("rand", b, $urandom_range(30, 100), $urandom_range(0, 31));
    end

    // Reset in the middle of a long block: stream must vanish without a done pulse.
    b = rand_blk(200, 1'b1);
    model(b);
    paddedText = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst/data_before", out_data, exp_b[3]);
    rst_n = 1'b0;
    #1;
    chk("midrst/out_valid", out_valid, 0);
    chk("midrst/out_last", out_last, 0);
    chk("midrst/out_data", out_data, 0);
    chk("midrst/done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst/in_ready_release", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst/no_done", done, 0);
      chk("midrst/no_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    b = rand_blk(40, 1'b1);
    run_block("after_rst", b, 80, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
